// File: rtl/lsu_pkg.sv
// Shared load/store definitions: funct3 encodings, FSM states and access-size helper.
// Pure declarations only; no timing or backpressure of its own.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    // Access size in bytes; the low two funct3 bits encode log2(size).
    function automatic logic [3:0] size_of(input logic [2:0] funct3);
        return 4'd1 << funct3[1:0];
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Load lane extract/extend and store byte merge for one 64-bit memory word.
// Purely combinational; zero latency, no backpressure.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  lane_i,
    input  logic [2:0]  funct3_i,
    input  logic [63:0] rdata_i,
    input  logic [63:0] merge_i,
    input  logic [63:0] wdata_i,
    output logic [63:0] load_o,
    output logic [63:0] store_o
);

    logic [63:0] shifted;
    logic [63:0] wdata_sh;
    logic [7:0]  size_mask;
    logic [7:0]  byte_en;
    logic [63:0] bit_en;

    assign shifted  = rdata_i >> {lane_i, 3'b000};
    assign wdata_sh = wdata_i << {lane_i, 3'b000};

    always_comb begin
        load_o = shifted;
        case (funct3_i)
            F3_B:    load_o = {{56{shifted[7]}},  shifted[7:0]};
            F3_H:    load_o = {{48{shifted[15]}}, shifted[15:0]};
            F3_W:    load_o = {{32{shifted[31]}}, shifted[31:0]};
            F3_D:    load_o = shifted;
            F3_BU:   load_o = {56'd0, shifted[7:0]};
            F3_HU:   load_o = {48'd0, shifted[15:0]};
            F3_WU:   load_o = {32'd0, shifted[31:0]};
            default: load_o = 64'd0;
        endcase
    end

    always_comb begin
        size_mask = 8'h01;
        case (funct3_i[1:0])
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    // Alignment is guaranteed upstream, so the shifted mask never spills past byte 7.
    assign byte_en = size_mask << lane_i;

    always_comb begin
        bit_en = 64'd0;
        for (int i = 0; i < 8; i++) begin
            bit_en[i*8 +: 8] = {8{byte_en[i]}};
        end
    end

    assign store_o = (merge_i & ~bit_en) | (wdata_sh & bit_en);

endmodule

// File: rtl/load_store_unit.sv
// RV64 load/store unit: one request at a time, read-modify-write for sub-doubleword stores.
// Latency: load/SD 2 cycles, SB/SH/SW 3 cycles, error 1 cycle; req_ready only in IDLE, responses not back-pressured.
// Optional LSU_STATS_EN adds 32-bit load/store/error counters.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 64,
    parameter int ADDR_W    = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [63:0]       resp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata,
    output logic              mem_read,
    output logic              mem_write
`ifdef LSU_STATS_EN
    ,
    output logic [31:0]       stat_loads,
    output logic [31:0]       stat_stores,
    output logic [31:0]       stat_errors
`endif
);

    lsu_state_t        state_q;
    logic              write_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [63:0]       wdata_q;
    logic [63:0]       merge_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic [63:0]       resp_rdata_q;

    logic [3:0]        acc_size;
    logic [2:0]        align_mask;
    logic              misaligned;
    logic              out_of_range;
    logic              illegal_f3;
    logic              req_err;
    logic [63:0]       load_data;
    logic [63:0]       store_data;

    assign acc_size     = size_of(req_funct3);
    assign align_mask   = 3'(acc_size - 4'd1);
    assign misaligned   = (req_addr[2:0] & align_mask) != 3'd0;
    // Full-width compare so high address bits can never alias into the array.
    assign out_of_range = req_addr >= ADDR_W'(MEM_BYTES);
    assign illegal_f3   = (req_funct3 == 3'b111) || (req_write && req_funct3[2]);
    assign req_err      = misaligned || out_of_range || illegal_f3;

    assign req_ready  = (state_q == IDLE);
    assign mem_read   = (state_q == READ);
    assign mem_write  = (state_q == WRITE);
    assign mem_addr   = {addr_q[ADDR_W-1:3], 3'b000};
    assign mem_wdata  = store_data;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

    lsu_align u_align (
        .lane_i   (addr_q[2:0]),
        .funct3_i (funct3_q),
        .rdata_i  (mem_rdata),
        .merge_i  (merge_q),
        .wdata_i  (wdata_q),
        .load_o   (load_data),
        .store_o  (store_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            funct3_q     <= 3'd0;
            addr_q       <= '0;
            wdata_q      <= 64'd0;
            merge_q      <= 64'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 64'd0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        write_q      <= req_write;
                        funct3_q     <= req_funct3;
                        addr_q       <= req_addr;
                        wdata_q      <= req_wdata;
                        resp_rdata_q <= 64'd0;
                        if (req_err) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else if (req_write && req_funct3[1:0] == 2'b11) begin
                            state_q <= WRITE;
                        end else begin
                            state_q <= READ;
                        end
                    end
                end
                READ: begin
                    if (write_q) begin
                        merge_q <= mem_rdata;
                        state_q <= WRITE;
                    end else begin
                        resp_rdata_q <= load_data;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                WRITE: begin
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    resp_rdata_q <= 64'd0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef LSU_STATS_EN
    logic [31:0] loads_q;
    logic [31:0] stores_q;
    logic [31:0] errors_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            loads_q  <= 32'd0;
            stores_q <= 32'd0;
            errors_q <= 32'd0;
        end else if (resp_valid_q) begin
            if (resp_err_q) begin
                errors_q <= errors_q + 32'd1;
            end else if (write_q) begin
                stores_q <= stores_q + 32'd1;
            end else begin
                loads_q  <= loads_q + 32'd1;
            end
        end
    end

    assign stat_loads  = loads_q;
    assign stat_stores = stores_q;
    assign stat_errors = errors_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 64-byte memory model and a response/write scoreboard.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        resp_valid;
    logic        resp_err;
    logic [63:0] resp_rdata;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_read;
    logic        mem_write;
`ifdef LSU_STATS_EN
    logic [31:0] stat_loads;
    logic [31:0] stat_stores;
    logic [31:0] stat_errors;
    int e_loads = 0;
    int e_stores = 0;
    int e_errors = 0;
`endif

    load_store_unit #(.MEM_BYTES(64), .ADDR_W(64)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write)
`ifdef LSU_STATS_EN
        ,
        .stat_loads  (stat_loads),
        .stat_stores (stat_stores),
        .stat_errors (stat_errors)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mem [0:63];

    always @(posedge clk) begin
        if (mem_write) begin
            for (int i = 0; i < 8; i++) mem[{mem_addr[5:3], 3'(i)}] <= mem_wdata[i*8 +: 8];
        end
    end

    always_comb begin
        mem_rdata = 64'd0;
        for (int i = 0; i < 8; i++) mem_rdata[i*8 +: 8] = mem[{mem_addr[5:3], 3'(i)}];
    end

    typedef struct {
        logic        err;
        logic [63:0] rdata;
        int          lat;
        int          nrd;
        int          nwr;
        int          acc;
    } exp_t;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wr_q[$];

    int checks = 0;
    int passed = 0;
    int nrd = 0;
    int nwr = 0;
    logic both_seen = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            nrd = 0;
            nwr = 0;
        end else begin
            if (mem_read && mem_write) both_seen = 1'b1;
            if (mem_write) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", 64'd1, 64'd0);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chk("write_addr", mem_addr, w.addr);
                    chk("write_data", mem_wdata, w.data);
                end
            end
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("resp_err", {63'd0, resp_err}, {63'd0, e.err});
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_latency", 64'(cyc - e.acc), 64'(e.lat));
                    chk("mem_read_cycles", 64'(nrd), 64'(e.nrd));
                    chk("mem_write_cycles", 64'(nwr), 64'(e.nwr));
                end
                nrd = 0;
                nwr = 0;
            end else begin
                if (mem_read)  nrd++;
                if (mem_write) nwr++;
            end
        end
    end

    task automatic do_req(input logic w, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] wd, input logic e_err, input logic [63:0] e_rd,
                          input int e_lat, input int e_nr, input int e_nw);
        int guard;
        exp_t e;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) chk("req_ready_timeout", 64'd0, 64'd1);
        e.err = e_err; e.rdata = e_rd; e.lat = e_lat; e.nrd = e_nr; e.nwr = e_nw; e.acc = cyc;
        exp_q.push_back(e);
`ifdef LSU_STATS_EN
        if (e_err) e_errors++;
        else if (w) e_stores++;
        else e_loads++;
`endif
        @(posedge clk);
        #1 req_valid = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            chk("resp_timeout", 64'd1, 64'd0);
            exp_q.delete();
        end
    endtask

    task automatic expect_wr(input logic [63:0] a, input logic [63:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        wr_q.push_back(w);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        mem[8'h08] = 8'h80;
        mem[8'h09] = 8'hFF;
        mem[8'h10] = 8'h09;
        mem[8'h18] = 8'h06;
        mem[8'h30] = 8'h02;

        #2;
        chk("reset_ready", {63'd0, req_ready}, 64'd1);
        chk("reset_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("reset_resp_rdata", resp_rdata, 64'd0);
        chk("reset_mem_ctl", {62'd0, mem_read, mem_write}, 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        do_req(0, 3'b011, 64'h10, 0, 0, 64'h9, 2, 1, 0);
        do_req(0, 3'b000, 64'h08, 0, 0, 64'hFFFF_FFFF_FFFF_FF80, 2, 1, 0);
        do_req(0, 3'b100, 64'h08, 0, 0, 64'h80, 2, 1, 0);
        do_req(0, 3'b001, 64'h08, 0, 0, 64'hFFFF_FFFF_FFFF_FF80, 2, 1, 0);
        do_req(0, 3'b101, 64'h08, 0, 0, 64'hFF80, 2, 1, 0);
        do_req(0, 3'b010, 64'h08, 0, 0, 64'hFF80, 2, 1, 0);

        expect_wr(64'h18, 64'h0000_0000_00AB_0006);
        do_req(1, 3'b000, 64'h1A, 64'hAB, 0, 0, 3, 1, 1);
        do_req(0, 3'b011, 64'h18, 0, 0, 64'h0000_0000_00AB_0006, 2, 1, 0);

        do_req(0, 3'b010, 64'h22, 0, 1, 0, 1, 0, 0);
        do_req(1, 3'b011, 64'h40, 64'h1234, 1, 0, 1, 0, 0);
        do_req(0, 3'b111, 64'h00, 0, 1, 0, 1, 0, 0);
        do_req(1, 3'b100, 64'h10, 64'h55, 1, 0, 1, 0, 0);
        do_req(0, 3'b011, 64'h8000_0000_0000_0010, 0, 1, 0, 1, 0, 0);

        expect_wr(64'h20, 64'h0000_0000_8000_0001);
        do_req(1, 3'b010, 64'h20, 64'hFFFF_FFFF_8000_0001, 0, 0, 3, 1, 1);
        expect_wr(64'h20, 64'hBEEF_0000_8000_0001);
        do_req(1, 3'b001, 64'h26, 64'h1234_BEEF, 0, 0, 3, 1, 1);
        do_req(0, 3'b010, 64'h20, 0, 0, 64'hFFFF_FFFF_8000_0001, 2, 1, 0);
        do_req(0, 3'b110, 64'h20, 0, 0, 64'h0000_0000_8000_0001, 2, 1, 0);
        do_req(0, 3'b001, 64'h26, 0, 0, 64'hFFFF_FFFF_FFFF_BEEF, 2, 1, 0);

        expect_wr(64'h38, 64'h0123_4567_89AB_CDEF);
        do_req(1, 3'b011, 64'h38, 64'h0123_4567_89AB_CDEF, 0, 0, 2, 0, 1);
        do_req(0, 3'b011, 64'h38, 0, 0, 64'h0123_4567_89AB_CDEF, 2, 1, 0);
        do_req(0, 3'b000, 64'h3F, 0, 0, 64'h1, 2, 1, 0);

        // SH aborted by reset during its READ cycle: no write, no response.
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'b001;
        req_addr   = 64'h30;
        req_wdata  = 64'h5555;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("abort_in_read", {63'd0, mem_read}, 64'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_ready", {63'd0, req_ready}, 64'd1);
        chk("abort_mem_write", {63'd0, mem_write}, 64'd0);
        chk("abort_resp_valid", {63'd0, resp_valid}, 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
`ifdef LSU_STATS_EN
        e_loads = 0; e_stores = 0; e_errors = 0;
`endif
        do_req(0, 3'b011, 64'h30, 0, 0, 64'h2, 2, 1, 0);
        do_req(1, 3'b011, 64'h48, 64'h1, 1, 0, 1, 0, 0);

        chk("read_write_exclusive", {63'd0, both_seen}, 64'd0);
        chk("pending_writes", 64'(wr_q.size()), 64'd0);

`ifdef LSU_STATS_EN
        @(negedge clk);
        chk("stat_loads", {32'd0, stat_loads}, 64'(e_loads));
        chk("stat_stores", {32'd0, stat_stores}, 64'(e_stores));
        chk("stat_errors", {32'd0, stat_errors}, 64'(e_errors));
        reset_n = 1'b0;
        #1;
        chk("stat_clear", {stat_loads, stat_stores | stat_errors}, 64'd0);
        reset_n = 1'b1;
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sits between the execute stage (ALU address and rs2 data) and the 64-bit byte-addressed data memory.
- Accepts one load/store request at a time over a valid/ready handshake.
- Supports RV64 sizes B/H/W/D with sign or zero extension.
- The data memory always writes 8 bytes per access, so sub-doubleword stores use a read-modify-write sequence.
- Rejects misaligned and out-of-range accesses with an error response instead of touching memory.

Parameters:
MEM_BYTES, 64, size of the data memory in bytes; must be a multiple of 8.
ADDR_W, 64, address width.

Ports:
clk  in  1  clock; all state updates on rising edge
reset_n  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request (high only in IDLE)
req_write  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU (stores use 000-011 only)
req_addr  in  ADDR_W  byte address
req_wdata  in  64  store data (rs2)
resp_valid  out  1  one-cycle response pulse
resp_err  out  1  access was misaligned, out of range, or used an illegal funct3; valid with resp_valid
resp_rdata  out  64  extended load data; 0 for stores and errors
mem_addr  out  ADDR_W  memory address, always 8-byte aligned ({addr[ADDR_W-1:3],3'b000})
mem_wdata  out  64  memory write data
mem_read  out  1  memory read enable; memory read is combinational
mem_write  out  1  memory write enable; memory writes on posedge clk

Behaviour:
- States: IDLE, READ, WRITE, RESP.
- Reset (asynchronous, on reset_n low):
  - state = IDLE.
  - resp_valid, resp_err, mem_read, mem_write = 0; resp_rdata = 0.
  - All captured request registers = 0.
- Handshake:
  - Request accepted when req_valid && req_ready.
  - Accept captures write, funct3, addr, wdata.
  - req_ready = (state == IDLE).
  - Responses are not back-pressured.
- Error check at accept (combinational on inputs):
  - err = (addr & (size-1)) != 0, where size = 1/2/4/8; OR addr >= MEM_BYTES; OR illegal funct3 (111 any; 1xx on store).
  - On err: IDLE -> RESP directly, no memory access.
- Transitions on a legal request:
  - Load: IDLE -> READ -> RESP.
  - SD: IDLE -> WRITE -> RESP.
  - SB/SH/SW: IDLE -> READ -> WRITE -> RESP.
  - RESP -> IDLE unconditionally.
- READ:
  - mem_read = 1, mem_addr = aligned address.
  - Load: lane = addr[2:0]; shifted = mem_rdata >> (lane*8); register extended result (B/H/W sign-extend, BU/HU/WU zero-extend, D as-is) into resp_rdata at end of cycle.
  - Store RMW: register mem_rdata into the merge buffer.
- WRITE:
  - mem_write = 1, mem_addr = aligned address.
  - mem_wdata = merge buffer with bytes [lane, lane+size-1] replaced by the low size bytes of wdata.
  - SD writes wdata unmodified.
- RESP:
  - resp_valid = 1 for exactly one cycle.
  - resp_err as computed; resp_rdata = load result, else 0.
- mem_read and mem_write are decoded combinationally from state; both are 0 in IDLE and RESP and never high together.
- Latency from accept to resp_valid:
  - Load: 2 cycles.
  - SD: 2 cycles.
  - Sub-doubleword store: 3 cycles.
  - Error: 1 cycle.
- Throughput: the next request is accepted no earlier than the cycle after RESP.
- Reset mid-operation returns to IDLE immediately and drops mem_write. An RMW aborted before its WRITE posedge leaves memory unchanged. No response is issued for an aborted request.
- Addresses wider than log2(MEM_BYTES) bits are range-checked, not truncated.

Optional Feature:
LSU_STATS_EN
- Defined: adds outputs stat_loads, stat_stores, stat_errors, each 32-bit.
  - Counters increment in the RESP cycle according to request type: stat_errors if err, otherwise stat_loads or stat_stores.
  - Counters clear on reset and wrap at 2^32.
- Undefined: ports and counters are absent. Core behaviour is identical.

Decomposition:
- Package lsu_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU).
  - State enum lsu_state_t {IDLE, READ, WRITE, RESP}.
  - Function size_of(funct3).
- Sub-module lsu_align (purely combinational): load extract/extend and store byte merge, given lane, funct3, and data.
- The FSM and registers stay in load_store_unit.

Test Plan:
- Memory preloaded with byte 0x10 = 9. LD addr 0x10 -> resp_valid exactly 2 cycles after accept, rdata = 9, err = 0; mem_read high only in the READ cycle.
- Memory bytes 0x08..0x0F = 0x80,0xFF,0,...; LB 0x08 -> 0xFFFF_FFFF_FFFF_FF80; LBU 0x08 -> 0x80; LH 0x08 -> 0xFFFF_FFFF_FFFF_FF80; LHU 0x08 -> 0xFF80.
- Memory bytes 0x18..0x1F = 06 00.. ; SB 0x1A with wdata 0xAB -> one mem_write with mem_addr 0x18, mem_wdata 0x0000_0000_00AB_0006; a following LD 0x18 returns the same value.
- Error cases, each with resp_valid and err = 1 after 1 cycle, no mem_read/mem_write, rdata = 0:
  - LW 0x22 (misaligned).
  - SD 0x40 (out of range at MEM_BYTES = 64).
  - funct3 = 111.
- Assert reset_n low in the READ cycle of SH 0x30 -> state IDLE, no mem_write, no resp; a later LD 0x30 returns the original value 2.
- With LSU_STATS_EN defined: 3 loads, 2 stores, 1 error -> stat_loads = 3, stat_stores = 2, stat_errors = 1; all return to 0 after reset.
